ro_meas_ctrl: RTL and testbench
===============================

RO_MEAS_CTRL -- requirements
Module: ro_meas_ctrl

Interface
REQ-001 SHALL have parameter NUM_RO, default 16, meaning number of ring oscillators in the bank.
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of the per-RO edge count.
REQ-003 SHALL have parameter WIN_W, default 16, meaning width of the gate-window length.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 64, meaning ACLK cycles from RO enable to count clear.
REQ-005 SHALL have parameter DRAIN_CYCLES, default 4, meaning ACLK cycles from gate close to count sample, covering synchronizer latency.
REQ-006 SHALL have parameter AVG_LOG, default 2, meaning log2 of repeats per RO when averaging is compiled in.
REQ-007 SHALL have ports ACLK in 1 (clock) and ARESET in 1 (reset); one clock, reset synchronous and active-high.
REQ-008 SHALL have ports start in 1 (sweep request pulse) and abort in 1 (terminate sweep).
REQ-009 SHALL have ports ro_first in $clog2(NUM_RO) and ro_last in $clog2(NUM_RO) (inclusive sweep range) and window_cycles in WIN_W (gate length).
REQ-010 SHALL have ports ro_sel out $clog2(NUM_RO) (RO select), ro_en out 1 (oscillate enable), ro_cnt_clr out 1 (count clear pulse) and ro_gate out 1 (count gate).
REQ-011 SHALL have port ro_cnt_in in CNT_W, meaning the synchronized count from the RO-domain counter.
REQ-012 SHALL have ports res_valid out 1, res_ready in 1, res_idx out $clog2(NUM_RO) and res_data out CNT_W+AVG_LOG, forming the result handshake to the register file.
REQ-013 SHALL have ports busy out 1, done out 1 (one-cycle pulse) and err out 1 (valid with done).

Function
REQ-014 SHALL implement states IDLE, SETTLE, CLEAR, GATE, DRAIN, WRITE, FINISH.
REQ-015 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-016 On accepted start with ro_first>ro_last or ro_last>=NUM_RO: next cycle done=1 and err=1, no RO enabled, return to IDLE.
REQ-017 On valid start, the controller SHALL latch ro_first, ro_last and window_cycles, set ro_sel=ro_first and ro_en=1 next cycle, and enter SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then CLEAR asserts ro_cnt_clr for exactly 1 cycle.
REQ-019 GATE SHALL hold ro_gate=1 for exactly the latched window_cycles cycles; window_cycles=0 SHALL be treated as 1.
REQ-020 DRAIN SHALL hold ro_gate=0 for DRAIN_CYCLES cycles, then sample ro_cnt_in into the accumulator.
REQ-021 WRITE SHALL assert res_valid with res_idx=ro_sel, with res_data and res_idx stable until the cycle res_ready=1; the transfer completes on res_valid&&res_ready.
REQ-022 After transfer, if ro_sel==ro_last go to FINISH; else ro_sel+1, accumulator cleared, SETTLE. ro_en SHALL stay 1 across RO changes.
REQ-023 FINISH SHALL drop ro_en, pulse done=1 with err=0 for one cycle, and return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 abort in any non-IDLE state SHALL, next cycle, force IDLE, ro_en=0, ro_gate=0, res_valid=0, and pulse done=1 with err=1; abort has priority over simultaneous start, res_ready or state exit.
REQ-026 The single-RO case ro_first==ro_last SHALL produce exactly one result.

Reset
REQ-027 ARESET SHALL, at any time including mid-sweep, force IDLE, with ro_sel=0, ro_en=0, ro_cnt_clr=0, ro_gate=0, res_valid=0, res_idx=0, res_data=0, busy=0, done=0 and err=0.

Configuration
REQ-028 With RO_MEAS_AVG_EN defined, each RO SHALL run SETTLE is skipped on repeats; CLEAR–GATE–DRAIN 2^AVG_LOG times, with samples summed into res_data (CNT_W+AVG_LOG bits, no overflow).
REQ-029 Without RO_MEAS_AVG_EN, each RO SHALL be measured once, res_data[CNT_W-1:0] SHALL equal the sample, and the upper AVG_LOG bits SHALL be 0.

Structure
REQ-030 The state enum type and the default parameter constants SHALL reside in package ro_meas_pkg.
REQ-031 A sub-module ro_meas_timer SHALL provide the loadable down-counter shared by SETTLE, GATE and DRAIN.

Verification
REQ-032 Bench SHALL cover: start, first=2, last=4, window=100, model counts 1000/2000/3000 -> res_idx 2,3,4 with data 1000,2000,3000 in order, done=1 err=0, ro_en low after.
REQ-033 Bench SHALL cover: res_ready held low 20 cycles in WRITE -> res_valid, res_idx and res_data stable for all 20 cycles, exactly one transfer.
REQ-034 Bench SHALL cover: start with first=5, last=3 -> done=1 err=1 next cycle, ro_en never asserted.
REQ-035 Bench SHALL cover: abort asserted 10 cycles into GATE -> IDLE, ro_gate=0, ro_en=0, done=1 err=1 next cycle; a new start then succeeds.
REQ-036 Bench SHALL cover: window_cycles=0 -> ro_gate high exactly 1 cycle; ARESET mid-SETTLE -> all outputs at reset values next cycle.
REQ-037 Bench SHALL cover, with RO_MEAS_AVG_EN and AVG_LOG=2: samples 10, 11, 12, 13 -> res_data=46.

Source files
------------

// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared state type, default parameters and helper for the RO measurement controller
package ro_meas_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, CLEAR, GATE, DRAIN, WRITE, FINISH} state_t;

    localparam int NUM_RO_D  = 16;
    localparam int CNT_W_D   = 32;
    localparam int WIN_W_D   = 16;
    localparam int SETTLE_D  = 64;
    localparam int DRAIN_D   = 4;
    localparam int AVG_LOG_D = 2;

    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction

endpackage

// File: rtl/ro_meas_timer.sv
// ro_meas_timer: loadable down-counter timing the SETTLE, GATE and DRAIN phases
module ro_meas_timer
    import ro_meas_pkg::*;
#(
    parameter int W = WIN_W_D
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // load wins; otherwise count down and park at zero
    always_ff @(posedge ACLK) begin
        if (ARESET) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = cnt == '0;

endmodule

// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl: sweeps a ring-oscillator bank, gating each RO's counter and handing results to the register file
// Optional averaging (2^AVG_LOG repeats per RO, samples summed) is built when RO_MEAS_AVG_EN is defined.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int NUM_RO        = NUM_RO_D,
    parameter int CNT_W         = CNT_W_D,
    parameter int WIN_W         = WIN_W_D,
    parameter int SETTLE_CYCLES = SETTLE_D,
    parameter int DRAIN_CYCLES  = DRAIN_D,
    parameter int AVG_LOG       = AVG_LOG_D
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       start,
    input  logic                       abort,
    input  logic [$clog2(NUM_RO)-1:0]  ro_first,
    input  logic [$clog2(NUM_RO)-1:0]  ro_last,
    input  logic [WIN_W-1:0]           window_cycles,
    output logic [$clog2(NUM_RO)-1:0]  ro_sel,
    output logic                       ro_en,
    output logic                       ro_cnt_clr,
    output logic                       ro_gate,
    input  logic [CNT_W-1:0]           ro_cnt_in,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(NUM_RO)-1:0]  res_idx,
    output logic [CNT_W+AVG_LOG-1:0]   res_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int SW = $clog2(NUM_RO);
    localparam int DW = CNT_W + AVG_LOG;
    localparam int TW = max3(WIN_W, $clog2(SETTLE_CYCLES + 1), $clog2(DRAIN_CYCLES + 1));

    state_t          state, nxt;
    logic [SW-1:0]   last;
    logic [WIN_W-1:0] win;
    logic [DW-1:0]   acc;
    logic            done_q, err_q, ld, tz, last_rep, bad;
    logic [TW-1:0]   ld_val;

`ifdef RO_MEAS_AVG_EN
    logic [AVG_LOG-1:0] rep;
    assign last_rep = &rep;
`else
    assign last_rep = 1'b1;
`endif

    assign bad = ro_first > ro_last || 32'(ro_last) >= NUM_RO;

    ro_meas_timer #(.W(TW)) u_timer (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .load     (ld),
        .load_val (ld_val),
        .zero     (tz)
    );

    // next state and timer loads; each timed phase loads N-1 on entry so it lasts N cycles
    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        case (state)
            IDLE: if (start && !bad) begin
                nxt    = SETTLE;
                ld     = 1'b1;
                ld_val = TW'(SETTLE_CYCLES - 1);
            end
            SETTLE: nxt = tz ? CLEAR : SETTLE;
            CLEAR: begin
                nxt    = GATE;
                ld     = 1'b1;
                ld_val = TW'(win == '0 ? '0 : win - 1'b1);
            end
            GATE: if (tz) begin
                nxt    = DRAIN;
                ld     = 1'b1;
                ld_val = TW'(DRAIN_CYCLES - 1);
            end
            DRAIN: nxt = !tz ? DRAIN : last_rep ? WRITE : CLEAR;
            WRITE: if (res_ready) begin
                nxt    = ro_sel == last ? FINISH : SETTLE;
                ld     = 1'b1;
                ld_val = TW'(SETTLE_CYCLES - 1);
            end
            FINISH: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (abort && state != IDLE) nxt = IDLE;
    end

    // state, sweep bookkeeping, accumulator and error/done flags
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state  <= IDLE;
            ro_sel <= '0;
            last   <= '0;
            win    <= '0;
            acc    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef RO_MEAS_AVG_EN
            rep    <= '0;
`endif
        end else begin
            state  <= nxt;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort && state != IDLE) begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
            end else if (state == IDLE && start) begin
                if (bad) begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                end else begin
                    ro_sel <= ro_first;
                    last   <= ro_last;
                    win    <= window_cycles;
                    acc    <= '0;
`ifdef RO_MEAS_AVG_EN
                    rep    <= '0;
`endif
                end
            end else if (state == DRAIN && tz) begin
`ifdef RO_MEAS_AVG_EN
                acc <= acc + DW'(ro_cnt_in);
                rep <= rep + 1'b1;
`else
                acc <= DW'(ro_cnt_in);
`endif
            end else if (state == WRITE && res_ready && ro_sel != last) begin
                ro_sel <= ro_sel + 1'b1;
                acc    <= '0;
`ifdef RO_MEAS_AVG_EN
                rep    <= '0;
`endif
            end
        end
    end

    assign ro_en      = state inside {SETTLE, CLEAR, GATE, DRAIN, WRITE};
    assign ro_cnt_clr = state == CLEAR;
    assign ro_gate    = state == GATE;
    assign res_valid  = state == WRITE;
    assign res_idx    = ro_sel;
    assign res_data   = acc;
    assign busy       = state != IDLE;
    assign done       = done_q || state == FINISH;
    assign err        = err_q;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb_ro_meas_ctrl: randomized scoreboard bench for ro_meas_ctrl with a rate-based RO counter model
module tb_ro_meas_ctrl;

    typedef struct {
        logic [3:0]  idx;
        logic [33:0] data;
    } exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET, start, abort, res_ready;
    logic [3:0]  ro_first, ro_last, ro_sel, res_idx;
    logic [15:0] window_cycles;
    logic        ro_en, ro_cnt_clr, ro_gate, res_valid, busy, done, err;
    logic [31:0] ro_cnt_in = '0;
    logic [33:0] res_data;

    exp_t        res_q[$];
    logic        done_q[$];
    int unsigned rate[16];
    int          total = 0, bad = 0, mode = 2, xfers = 0, gate_cnt = 0;
    logic        en_seen = 1'b0;

    ro_meas_ctrl dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .abort         (abort),
        .ro_first      (ro_first),
        .ro_last       (ro_last),
        .window_cycles (window_cycles),
        .ro_sel        (ro_sel),
        .ro_en         (ro_en),
        .ro_cnt_clr    (ro_cnt_clr),
        .ro_gate       (ro_gate),
        .ro_cnt_in     (ro_cnt_in),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_idx       (res_idx),
        .res_data      (res_data),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event occurred or timed out unexpectedly", name);
    endtask

    // RO counter model: clear loads the repeat index, each gated cycle adds the RO's rate
    initial begin
        logic       c, g, en;
        logic [3:0] s, psel;
        logic [31:0] cnt;
        int         jit;
        cnt = '0; jit = 0; psel = '0;
        forever begin
            @(posedge ACLK);
            c = ro_cnt_clr; g = ro_gate; s = ro_sel; en = ro_en;
            #1;
            if (!en || s != psel) jit = 0;
            psel = s;
            if (c) begin
                cnt = 32'(jit);
                jit++;
            end else if (g) cnt = cnt + rate[s];
            ro_cnt_in = cnt;
        end
    end

    // result consumer: random, stalled or always ready
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            res_ready = mode == 0 ? 1'($urandom_range(0, 1)) : (mode == 2);
        end
    end

    // monitor: pops the scoreboard on every transfer and every done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (ro_gate) gate_cnt++;
                if (ro_en) en_seen = 1'b1;
                if (res_valid && res_ready) begin
                    xfers++;
                    if (res_q.size() == 0) fail_now("xfer_unexpected");
                    else begin
                        e = res_q.pop_front();
                        check("res_idx", 64'(res_idx), 64'(e.idx));
                        check("res_data", 64'(res_data), 64'(e.data));
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) fail_now("done_unexpected");
                    else check("done_err", 64'(err), 64'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic push_expect(input int f, input int l, input int w);
        exp_t   e;
        longint weff;
        weff = (w == 0) ? 1 : w;
        if (f > l) begin
            done_q.push_back(1'b1);
            return;
        end
        for (int i = f; i <= l; i++) begin
            e.idx = 4'(i);
`ifdef RO_MEAS_AVG_EN
            e.data = 34'(4 * weff * rate[i] + 6);
`else
            e.data = 34'(weff * rate[i]);
`endif
            res_q.push_back(e);
        end
        done_q.push_back(1'b0);
    endtask

    task automatic pulse_start(input int f, input int l, input int w);
        @(posedge ACLK);
        #1;
        ro_first = 4'(f);
        ro_last = 4'(l);
        window_cycles = 16'(w);
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20000) begin
            @(negedge ACLK);
            n++;
        end
        if (!done) fail_now(name);
    endtask

    task automatic run(input int f, input int l, input int w);
        push_expect(f, l, w);
        pulse_start(f, l, w);
        wait_done("run_timeout");
        check("ro_en_after", 64'(ro_en), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ro_sel"}, 64'(ro_sel), 64'd0);
        check({tag, "_ro_en"}, 64'(ro_en), 64'd0);
        check({tag, "_ro_cnt_clr"}, 64'(ro_cnt_clr), 64'd0);
        check({tag, "_ro_gate"}, 64'(ro_gate), 64'd0);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_idx"}, 64'(res_idx), 64'd0);
        check({tag, "_res_data"}, 64'(res_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
    endtask

    initial begin
        logic [3:0]  cap_idx;
        logic [33:0] cap_data;
        int          n, x0, f, l;
        ARESET = 1'b1; start = 1'b0; abort = 1'b0;
        ro_first = '0; ro_last = '0; window_cycles = '0;
        for (int i = 0; i < 16; i++) rate[i] = $urandom_range(1, 1000);
        rate[2] = 10; rate[3] = 20; rate[4] = 30;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        check_reset("por");

        mode = 0;
        run(2, 4, 100);

        mode = 1;
        push_expect(6, 6, 3);
        x0 = xfers;
        pulse_start(6, 6, 3);
        n = 0;
        while (!res_valid && n < 5000) begin
            @(negedge ACLK);
            n++;
        end
        if (!res_valid) fail_now("stall_no_valid");
        cap_idx = res_idx;
        cap_data = res_data;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            check("stall_valid", 64'(res_valid), 64'd1);
            check("stall_idx", 64'(res_idx), 64'(cap_idx));
            check("stall_data", 64'(res_data), 64'(cap_data));
        end
        mode = 2;
        wait_done("stall_timeout");
        check("stall_xfers", 64'(xfers - x0), 64'd1);

        en_seen = 1'b0;
        push_expect(5, 3, 10);
        pulse_start(5, 3, 10);
        check("bad_done", 64'(done), 64'd1);
        check("bad_err", 64'(err), 64'd1);
        repeat (5) @(negedge ACLK);
        check("bad_en_seen", 64'(en_seen), 64'd0);

        done_q.push_back(1'b1);
        pulse_start(0, 0, 200);
        n = 0;
        while (!ro_gate && n < 5000) begin
            @(negedge ACLK);
            n++;
        end
        if (!ro_gate) fail_now("abort_no_gate");
        repeat (9) @(posedge ACLK);
        #1 abort = 1'b1;
        @(posedge ACLK);
        #1 abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_gate", 64'(ro_gate), 64'd0);
        check("abort_en", 64'(ro_en), 64'd0);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_done", 64'(done), 64'd1);
        check("abort_err", 64'(err), 64'd1);
        run(1, 2, 5);

        gate_cnt = 0;
        run(7, 7, 0);
        check("gate_w0", 64'(gate_cnt), 64'd1);

        pulse_start(3, 5, 10);
        repeat (5) @(posedge ACLK);
        #1 ARESET = 1'b1;
        res_q.delete();
        done_q.delete();
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        check_reset("mid");

`ifdef RO_MEAS_AVG_EN
        rate[9] = 10;
        res_q.push_back('{4'd9, 34'd46});
        done_q.push_back(1'b0);
        pulse_start(9, 9, 1);
        wait_done("avg_timeout");
`endif

        mode = 0;
        for (int k = 0; k < 5; k++) begin
            f = $urandom_range(0, 15);
            l = f + $urandom_range(0, (15 - f) < 2 ? 15 - f : 2);
            run(f, l, $urandom_range(0, 40));
        end

        repeat (5) @(negedge ACLK);
        check("res_q_empty", 64'(res_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
